xbar_slave_arbiter: RTL and testbench
=====================================

# xbar_slave_arbiter

Round-robin arbiter that owns the `granted_master` vector feeding one crossbar slave port's response parser. It collects the `_req` lines of all masters, grants exactly one at a time, and holds that grant until the parser reports `session_is_finished`. A watchdog aborts sessions the slave never completes. One instance sits beside each slave-port parser in the crossbar top level.

## Interface
- `QTY_OF_DEVICES`, 4: number of masters. Sets the width of the request and grant vectors.
- `TIMEOUT_CYCLES`, 256: maximum number of BUSY cycles before abort. Must be ≥2.
- `clk` input 1: single clock. All logic is on the rising edge.
- `rst_n` input 1: reset, synchronous, active-low.
- `master_req` input QTY_OF_DEVICES: `_req` of each master for this slave port, bit i = master i.
- `session_is_finished` input 1: one-cycle pulse from the response parser.
- `granted_master` output QTY_OF_DEVICES: one-hot or zero. Goes to the parser and the crossbar mux.
- `granted_id` output $clog2(QTY_OF_DEVICES): binary index of the current grant. Equals 0 when there is no grant.
- `busy` output 1: a grant is held (state BUSY).
- `timeout_abort` output 1: one-cycle pulse when the watchdog fires. The top level uses it to reset the parser.

## Operation
- Reset (`rst_n` low at a clock edge):
  - `grant_reg` = 0, state = IDLE, priority pointer `ptr` = 0, watchdog = 0, `timeout_abort` = 0.
  - All outputs are therefore 0.
- **IDLE state:**
  - If `|master_req`, pick the first set bit scanning from `ptr` upward, modulo N.
  - Register its one-hot value into `grant_reg`, clear the watchdog, go to BUSY.
  - If no request is set, stay in IDLE.
- **BUSY state:**
  - The grant is held regardless of `master_req`. A master dropping `_req` mid-session does not release the grant.
  - The watchdog increments every BUSY cycle.
  - If `session_is_finished`: clear `grant_reg`, set `ptr` = (granted index + 1) mod N, go to IDLE.
  - Otherwise, if watchdog == TIMEOUT_CYCLES-1: pulse `timeout_abort`, clear `grant_reg`, advance `ptr` the same way, go to IDLE.
  - If both occur in the same cycle, finish wins and there is no abort.
- Output masking:
  - `granted_master` = `grant_reg` & ~{N{`session_is_finished`}}.
  - Purpose: the parser, which returns to waiting for a request on the finish edge, must not see a stale grant and restart a session.
- `busy` = (state == BUSY).
- `granted_id` is encoded from `granted_master` after masking.
- No rotation on idle cycles. `ptr` changes only when a grant ends.
- Fairness: a continuously requesting master waits at most N-1 sessions.

## Timing
- Request to grant:
  - `master_req` sampled high at edge k while in IDLE → `granted_master` valid after edge k.
  - One cycle of latency, registered.
- Finish to release:
  - `granted_master` drops combinationally in the cycle `session_is_finished` is high.
  - `grant_reg` clears at the following edge.
- Back-to-back sessions:
  - There is at least one cycle with no grant between sessions: the finish cycle, then one IDLE cycle.
  - Next grant appears 2 cycles after the finish pulse begins.
- Watchdog:
  - The abort pulse occurs in the TIMEOUT_CYCLES-th BUSY cycle.
  - The grant is zero from the next cycle.
- Reset mid-session: takes effect at the next edge with all outputs 0. It is not gated by the session state.
- A `session_is_finished` pulse in IDLE is ignored.

## Structure
- Package `xbar_arb_pkg` contains:
  - the `arb_state_t` enum {enIDLE, enBUSY};
  - the `onehot_to_idx` function;
  - the default timeout constant.
- Sub-module `rr_priority_picker`:
  - combinational; inputs `req` and `ptr`; output one-hot `pick`;
  - implemented as a double-width vector, masked and priority-encoded.
- The arbiter top holds the FSM, `grant_reg`, `ptr` and the watchdog.

## Test plan
- **Reset, then single request:** reset, then `master_req`=4'b0100 → `granted_master`=4'b0100 and `granted_id`=2 after one edge. Grant holds until finish, is 0 during the finish cycle, and `ptr`=3 afterwards.
- **All masters requesting continuously:** `master_req`=4'b1111 with the parser model finishing each session after 3 cycles → grant order 0,1,2,3,0. Exactly one IDLE cycle between grants.
- **Request dropped mid-session:** master 1 granted, `master_req` drops to 0 in BUSY → grant is still 4'b0010 until finish.
- **Timeout:** TIMEOUT_CYCLES=8, master 2 granted, no finish → `timeout_abort` pulses in BUSY cycle 8, grant becomes 0, `ptr`=3. With `master_req`=4'b1111 afterwards, master 3 is granted next.
- **Finish coincides with timeout:** finish in the same cycle as the timeout → no `timeout_abort` pulse, normal release.
- **Reset mid-session:** `rst_n` low while master 3 is busy → next edge gives `granted_master`=0, `busy`=0, `ptr`=0. A following `master_req`=4'b1001 grants master 0.

Source files
------------

// File: rtl/xbar_slave_arbiter_pkg.sv
// Shared types and helpers for the crossbar slave-port arbiter.
// Holds the FSM state type, the one-hot to index encoder and the default watchdog limit.
package xbar_arb_pkg;

  localparam int unsigned MaxDevices           = 32;
  localparam int unsigned DefaultTimeoutCycles = 256;

  typedef enum logic [0:0] {
    enIDLE = 1'b0,
    enBUSY = 1'b1
  } arb_state_t;

  // Returns 0 for an all-zero vector, so an idle grant encodes as index 0.
  function automatic int unsigned onehot_to_idx(input logic [MaxDevices-1:0] onehot);
    int unsigned idx;
    idx = 0;
    for (int i = 0; i < MaxDevices; i++) begin
      if (onehot[i]) begin
        idx = idx | i;
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/xbar_slave_arbiter_if.sv
// Request/grant bundle between the masters' _req lines, the slave-port parser and the arbiter.
// The arbiter sits on the slave modport; the request/finish side drives the master modport.
interface xbar_slave_arbiter_if #(
  parameter int unsigned QTY_OF_DEVICES = 4
) ();

  localparam int unsigned IdW = (QTY_OF_DEVICES > 1) ? $clog2(QTY_OF_DEVICES) : 1;

  logic [QTY_OF_DEVICES-1:0] master_req;
  logic                      session_is_finished;
  logic [QTY_OF_DEVICES-1:0] granted_master;
  logic [IdW-1:0]            granted_id;
  logic                      busy;
  logic                      timeout_abort;

  modport master (
    output master_req,
    output session_is_finished,
    input  granted_master,
    input  granted_id,
    input  busy,
    input  timeout_abort
  );

  modport slave (
    input  master_req,
    input  session_is_finished,
    output granted_master,
    output granted_id,
    output busy,
    output timeout_abort
  );

endinterface

// File: rtl/xbar_slave_arbiter_rr_priority_picker.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping modulo N.
// The request vector is doubled so the wrap becomes a plain lowest-bit priority search.
module rr_priority_picker #(
  parameter int unsigned N    = 4,
  parameter int unsigned PtrW = 2
) (
  input  logic [N-1:0]    req,
  input  logic [PtrW-1:0] ptr,
  output logic [N-1:0]    pick
);

  logic [2*N-1:0] dbl;
  logic [2*N-1:0] masked;
  logic           found;

  always_comb begin
    dbl    = {req, req};
    masked = '0;
    pick   = '0;
    found  = 1'b0;
    // Only the lower copy is masked, so every pending request is still reachable.
    for (int i = 0; i < 2 * N; i++) begin
      masked[i] = dbl[i] & (i >= int'(ptr));
    end
    for (int i = 0; i < 2 * N; i++) begin
      if (masked[i] && !found) begin
        pick[i % N] = 1'b1;
        found       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/xbar_slave_arbiter.sv
// Round-robin grant owner for one crossbar slave port, with a session watchdog.
// A grant is held until the parser finishes or the watchdog aborts the session.
module xbar_slave_arbiter
  import xbar_arb_pkg::*;
#(
  parameter int unsigned QTY_OF_DEVICES = 4,
  parameter int unsigned TIMEOUT_CYCLES = DefaultTimeoutCycles
) (
  input logic                 clk,
  input logic                 rst_n,
  xbar_slave_arbiter_if.slave bus
);

  localparam int unsigned N   = QTY_OF_DEVICES;
  localparam int unsigned IdW = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned WdW = $clog2(TIMEOUT_CYCLES);

  arb_state_t     state_q, state_d;
  logic [N-1:0]   grant_q, grant_d;
  logic [IdW-1:0] ptr_q, ptr_d;
  logic [WdW-1:0] wd_q, wd_d;

  logic [N-1:0]   pick;
  logic [N-1:0]   grant_masked;
  logic [IdW-1:0] grant_idx;
  logic [IdW-1:0] next_ptr;
  logic           finish;
  logic           wd_expired;
  logic           abort;

  rr_priority_picker #(
    .N    (N),
    .PtrW (IdW)
  ) u_picker (
    .req  (bus.master_req),
    .ptr  (ptr_q),
    .pick (pick)
  );

  assign finish     = bus.session_is_finished;
  assign grant_idx  = IdW'(onehot_to_idx(MaxDevices'(grant_q)));
  assign next_ptr   = (grant_idx == IdW'(N - 1)) ? '0 : grant_idx + 1'b1;
  assign wd_expired = (wd_q == WdW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    ptr_d   = ptr_q;
    wd_d    = wd_q;
    abort   = 1'b0;
    case (state_q)
      enIDLE: begin
        if (|bus.master_req) begin
          grant_d = pick;
          wd_d    = '0;
          state_d = enBUSY;
        end
      end
      enBUSY: begin
        wd_d = wd_q + 1'b1;
        // Finish takes precedence over a coincident watchdog expiry.
        if (finish) begin
          grant_d = '0;
          ptr_d   = next_ptr;
          state_d = enIDLE;
        end else if (wd_expired) begin
          abort   = 1'b1;
          grant_d = '0;
          ptr_d   = next_ptr;
          state_d = enIDLE;
        end
      end
      default: begin
        grant_d = '0;
        state_d = enIDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= enIDLE;
      grant_q <= '0;
      ptr_q   <= '0;
      wd_q    <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
      wd_q    <= wd_d;
    end
  end

  // Hide the grant on the finish edge so the parser cannot restart on a stale grant.
  assign grant_masked       = grant_q & ~{N{finish}};
  assign bus.granted_master = grant_masked;
  assign bus.granted_id     = IdW'(onehot_to_idx(MaxDevices'(grant_masked)));
  assign bus.busy           = (state_q == enBUSY);
  assign bus.timeout_abort  = abort;

endmodule

// File: tb/tb_xbar_slave_arbiter.sv
// Scoreboard bench for xbar_slave_arbiter (N=4, TIMEOUT_CYCLES=8).
// Stimulus pushes the expected outputs of each driven cycle; a negedge monitor pops and compares.
module tb_xbar_slave_arbiter;

  typedef struct {
    string      name;
    logic [3:0] grant;
    logic [1:0] id;
    logic       busy;
    logic       abort;
  } exp_t;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;
  exp_t exp_q[$];

  xbar_slave_arbiter_if #(.QTY_OF_DEVICES(4)) bus ();

  xbar_slave_arbiter #(
    .QTY_OF_DEVICES (4),
    .TIMEOUT_CYCLES (8)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle's inputs just after the edge and queue that cycle's expected outputs.
  task automatic cyc(input logic rst, input logic [3:0] req, input logic fin, input logic chk,
                     input logic [3:0] eg, input logic [1:0] eid, input logic eb,
                     input logic ea, input string nm);
    exp_t e;
    @(posedge clk);
    #1;
    rst_n                   = rst;
    bus.master_req          = req;
    bus.session_is_finished = fin;
    if (chk) begin
      e.name  = nm;
      e.grant = eg;
      e.id    = eid;
      e.busy  = eb;
      e.abort = ea;
      exp_q.push_back(e);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (bus.granted_master !== e.grant || bus.granted_id !== e.id ||
          bus.busy !== e.busy || bus.timeout_abort !== e.abort) begin
        failures++;
        $display("FAIL %s: got grant=%b id=%0d busy=%b abort=%b, want grant=%b id=%0d busy=%b abort=%b",
                 e.name, bus.granted_master, bus.granted_id, bus.busy, bus.timeout_abort,
                 e.grant, e.id, e.busy, e.abort);
      end
    end
  end

  initial begin
    logic [3:0] oh;
    checks                  = 0;
    failures                = 0;
    rst_n                   = 1'b0;
    bus.master_req          = '0;
    bus.session_is_finished = 1'b0;

    // Reset
    cyc(0, 4'b0000, 0, 0, 4'b0000, 0, 0, 0, "rst0");
    cyc(0, 4'b0000, 0, 1, 4'b0000, 0, 0, 0, "reset_state");

    // Single request from master 2
    cyc(1, 4'b0100, 0, 1, 4'b0000, 0, 0, 0, "single_idle");
    cyc(1, 4'b0100, 0, 1, 4'b0100, 2, 1, 0, "single_grant");
    cyc(1, 4'b0000, 0, 1, 4'b0100, 2, 1, 0, "single_hold");
    cyc(1, 4'b0000, 1, 1, 4'b0000, 0, 1, 0, "single_finish_mask");
    cyc(1, 4'b0000, 0, 1, 4'b0000, 0, 0, 0, "single_released");
    // ptr must now be 3
    cyc(1, 4'b1111, 0, 1, 4'b0000, 0, 0, 0, "ptr3_idle");
    cyc(1, 4'b1111, 0, 1, 4'b1000, 3, 1, 0, "ptr3_grant");
    cyc(1, 4'b1111, 1, 1, 4'b0000, 0, 1, 0, "ptr3_finish");
    cyc(1, 4'b1111, 0, 1, 4'b0000, 0, 0, 0, "ptr3_gap");

    // All masters requesting: order 0,1,2,3,0 with one IDLE gap each
    for (int k = 0; k < 5; k++) begin
      oh = 4'b0001 << (k % 4);
      cyc(1, 4'b1111, 0, 1, oh, 2'(k % 4), 1, 0, $sformatf("rr%0d_b1", k));
      cyc(1, 4'b1111, 0, 1, oh, 2'(k % 4), 1, 0, $sformatf("rr%0d_b2", k));
      cyc(1, 4'b1111, 1, 1, 4'b0000, 0, 1, 0, $sformatf("rr%0d_fin", k));
      cyc(1, 4'b1111, 0, 1, 4'b0000, 0, 0, 0, $sformatf("rr%0d_gap", k));
    end

    // Master 1 now granted; request dropped mid-session
    cyc(1, 4'b0000, 0, 1, 4'b0010, 1, 1, 0, "drop_hold1");
    cyc(1, 4'b0000, 0, 1, 4'b0010, 1, 1, 0, "drop_hold2");
    cyc(1, 4'b0000, 1, 1, 4'b0000, 0, 1, 0, "drop_finish");
    cyc(1, 4'b0000, 0, 1, 4'b0000, 0, 0, 0, "drop_idle");

    // Timeout on master 2
    cyc(1, 4'b0100, 0, 1, 4'b0000, 0, 0, 0, "to_idle");
    for (int c = 1; c <= 7; c++) begin
      cyc(1, 4'b0000, 0, 1, 4'b0100, 2, 1, 0, $sformatf("to_busy%0d", c));
    end
    cyc(1, 4'b0000, 0, 1, 4'b0100, 2, 1, 1, "to_abort");
    cyc(1, 4'b1111, 0, 1, 4'b0000, 0, 0, 0, "to_released");
    cyc(1, 4'b0000, 0, 1, 4'b1000, 3, 1, 0, "to_next_is3");

    // Finish coincides with watchdog expiry on master 3
    for (int c = 2; c <= 7; c++) begin
      cyc(1, 4'b0000, 0, 1, 4'b1000, 3, 1, 0, $sformatf("co_busy%0d", c));
    end
    cyc(1, 4'b0000, 1, 1, 4'b0000, 0, 1, 0, "co_finish_no_abort");
    cyc(1, 4'b0000, 0, 1, 4'b0000, 0, 0, 0, "co_idle");

    // Reset mid-session on master 3
    cyc(1, 4'b1000, 0, 1, 4'b0000, 0, 0, 0, "mr_idle");
    cyc(1, 4'b0000, 0, 1, 4'b1000, 3, 1, 0, "mr_busy");
    cyc(0, 4'b0000, 0, 1, 4'b1000, 3, 1, 0, "mr_rst_pending");
    cyc(1, 4'b1001, 0, 1, 4'b0000, 0, 0, 0, "mr_after_reset");
    cyc(1, 4'b0000, 0, 1, 4'b0001, 0, 1, 0, "mr_grant0");
    cyc(1, 4'b0000, 1, 1, 4'b0000, 0, 1, 0, "mr_finish");
    // Finish pulse while IDLE must be ignored
    cyc(1, 4'b0000, 1, 1, 4'b0000, 0, 0, 0, "idle_finish");
    cyc(1, 4'b0000, 0, 1, 4'b0000, 0, 0, 0, "idle_quiet");

    repeat (2) @(posedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: got %0d pending entries, want 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
